// File: rtl/frame_deframer_pkg.sv
//============================================================================
// frame_deframer_pkg : shared flag bytes, frame codes, error codes, CRC-32
// Revision 1.0 - initial release
//============================================================================
`default_nettype none

package frame_deframer_pkg;

  localparam logic [7:0] DEF_FRAME_START = 8'h06;
  localparam logic [7:0] DEF_FRAME_END   = 8'h07;
  localparam logic [7:0] DEF_ESC_VAL     = 8'h14;
  localparam logic [7:0] DEF_ESC_XOR     = 8'h20;

  typedef enum logic [7:0] {
    FT_DATA    = 8'h01,
    FT_CONFIRM = 8'h02,
    FT_ERROR   = 8'h03
  } frame_type_e;

  typedef enum logic [7:0] {
    CONF_OK    = 8'h00,
    CONF_ERROR = 8'hFF
  } confirm_code_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_ESC  = 2'd2,
    ERR_CRC  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_ESC  = 2'd2
  } state_e;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

`default_nettype wire

// File: rtl/frame_deframer_if.sv
//============================================================================
// frame_deframer_if : raw receive byte strobe in, assembled frame bus out
// Revision 1.0 - initial release
//============================================================================
`default_nettype none

interface frame_deframer_if #(
  parameter int FRAME_BYTES = 75
);
  localparam int FRAME_SIZE = FRAME_BYTES*8-1;

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic [0:FRAME_SIZE] fout;
  logic                fout_valid;
  logic                err_valid;
  logic [1:0]          err_code;
  logic                busy;

  modport master (
    output rx_byte, rx_valid,
    input  fout, fout_valid, err_valid, err_code, busy
  );

  modport slave (
    input  rx_byte, rx_valid,
    output fout, fout_valid, err_valid, err_code, busy
  );

endinterface

`default_nettype wire

// File: rtl/frame_deframer_crc32_byte.sv
//============================================================================
// crc32_byte : one-byte step of reflected CRC-32, purely combinational
// Revision 1.0 - initial release
//============================================================================
`default_nettype none

module crc32_byte
  import frame_deframer_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = i_crc ^ {24'h000000, i_data};
    for (int b = 0; b < 8; b++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
    end
  end

  assign o_crc = w_crc;

endmodule

`default_nettype wire

// File: rtl/frame_deframer.sv
//============================================================================
// frame_deframer : hunts FRAME_START, unstuffs, packs a fixed-length frame
// Optional CRC-32 check built when DEFRAMER_CRC_CHECK_EN is defined.
// Revision 1.0 - initial release
//============================================================================
`default_nettype none

module frame_deframer
  import frame_deframer_pkg::*;
#(
  parameter int         DATA_SIZE     = 64,
  parameter int         PREAMBLE_SIZE = 7,
  parameter int         CRC_SIZE      = 4,
  parameter logic [7:0] FRAME_START   = DEF_FRAME_START,
  parameter logic [7:0] FRAME_END     = DEF_FRAME_END,
  parameter logic [7:0] ESC_VAL       = DEF_ESC_VAL,
  parameter logic [7:0] ESC_XOR       = DEF_ESC_XOR
) (
  input  logic             clk,
  input  logic             rst,
  frame_deframer_if.slave  bus
);

  localparam int FRAME_BYTES = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int FRAME_SIZE  = FRAME_BYTES*8 - 1;
  localparam int CRC_BYTES   = PREAMBLE_SIZE + DATA_SIZE;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);

  localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] c_CRC_END = CNT_W'(CRC_BYTES);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [7:0]          r_shadow [FRAME_BYTES];
  logic [0:FRAME_SIZE] w_shadow_flat;
  logic [0:FRAME_SIZE] r_fout;
  logic                r_fout_valid;
  logic                r_err_valid;
  err_code_e           r_err_code;

  logic                w_full;
  logic                w_store;
  logic [7:0]          w_store_byte;
  logic                w_good;
  logic                w_err;
  err_code_e           w_err_code;
  logic                w_restart;
  logic                w_crc_ok;

  assign w_full = (r_count == c_FULL);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_store      = 1'b0;
    w_store_byte = bus.rx_byte;
    w_good       = 1'b0;
    w_err        = 1'b0;
    w_err_code   = ERR_LEN;
    w_restart    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_byte == FRAME_START)) begin
          w_state_nxt = ST_RECV;
          w_count_nxt = '0;
          w_restart   = 1'b1;
        end
      end

      ST_RECV: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == ESC_VAL) begin
            w_state_nxt = ST_ESC;
          end else if (bus.rx_byte == FRAME_END) begin
            w_state_nxt = ST_IDLE;
            if (!w_full) begin
              w_err      = 1'b1;
              w_err_code = ERR_LEN;
            end else if (!w_crc_ok) begin
              w_err      = 1'b1;
              w_err_code = ERR_CRC;
            end else begin
              w_good     = 1'b1;
            end
          end else if (bus.rx_byte == FRAME_START) begin
            // Resync: the new START opens a fresh frame immediately
            w_err       = 1'b1;
            w_err_code  = ERR_LEN;
            w_count_nxt = '0;
            w_restart   = 1'b1;
          end else if (w_full) begin
            w_err       = 1'b1;
            w_err_code  = ERR_LEN;
            w_state_nxt = ST_IDLE;
          end else begin
            w_store     = 1'b1;
            w_count_nxt = r_count + 1'b1;
          end
        end
      end

      ST_ESC: begin
        if (bus.rx_valid) begin
          if ((bus.rx_byte == FRAME_START) || (bus.rx_byte == FRAME_END) ||
              (bus.rx_byte == ESC_VAL)) begin
            w_err       = 1'b1;
            w_err_code  = ERR_ESC;
            w_state_nxt = ST_IDLE;
          end else if (w_full) begin
            w_err       = 1'b1;
            w_err_code  = ERR_LEN;
            w_state_nxt = ST_IDLE;
          end else begin
            w_store      = 1'b1;
            w_store_byte = bus.rx_byte ^ ESC_XOR;
            w_count_nxt  = r_count + 1'b1;
            w_state_nxt  = ST_RECV;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_fout       <= '0;
      r_fout_valid <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_fout_valid <= w_good;
      r_err_valid  <= w_err;
      if (w_good) begin
        r_fout <= w_shadow_flat;
      end
      if (w_err) begin
        r_err_code <= w_err_code;
      end
    end
  end

  // Shadow needs no reset: a good frame always rewrites every byte first
  always_ff @(posedge clk) begin
    if (!rst && w_store) begin
      r_shadow[r_count] <= w_store_byte;
    end
  end

  for (genvar k = 0; k < FRAME_BYTES; k++) begin : g_pack
    assign w_shadow_flat[8*k +: 8] = r_shadow[k];
  end

`ifdef DEFRAMER_CRC_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_step;
  logic [31:0] w_crc_rx;

  crc32_byte u_crc32_byte (
    .i_crc  (r_crc),
    .i_data (w_store_byte),
    .o_crc  (w_crc_step)
  );

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_crc <= CRC_INIT;
    end else if (w_store && (r_count < c_CRC_END)) begin
      r_crc <= w_crc_step;
    end
  end

  // Trailer carries the CRC least significant byte first
  for (genvar k = 0; k < 4; k++) begin : g_crc_rx
    assign w_crc_rx[8*k +: 8] = r_shadow[CRC_BYTES + k];
  end

  assign w_crc_ok = (w_crc_rx == ~r_crc);
`else
  assign w_crc_ok = 1'b1;
`endif

  assign bus.fout       = r_fout;
  assign bus.fout_valid = r_fout_valid;
  assign bus.err_valid  = r_err_valid;
  assign bus.err_code   = r_err_code;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_frame_deframer.sv
//============================================================================
// tb_frame_deframer : table vectors, corner sequences and random frames
// checked every cycle against a queue-based frame model.
// Revision 1.0 - initial release
//============================================================================
`default_nettype none

module tb_frame_deframer;

  localparam int FB        = 75;
  localparam int FS        = FB*8 - 1;
  localparam int CRC_BYTES = 71;
  localparam logic [7:0] START = 8'h06;
  localparam logic [7:0] FEND  = 8'h07;
  localparam logic [7:0] ESC   = 8'h14;
  localparam logic [7:0] XORV  = 8'h20;
`ifdef DEFRAMER_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  localparam int K_PLAIN   = 0;
  localparam int K_BADESC  = 1;
  localparam int K_RESYNC  = 2;
  localparam int K_CRCFLIP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_deframer_if #(.FRAME_BYTES(FB)) bus ();

  frame_deframer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference: a byte queue plus "inside frame"/"after escape"
  bit          m_in   = 1'b0;
  bit          m_esc  = 1'b0;
  logic [7:0]  m_q[$];
  logic [0:FS] m_fout = '0;
  logic [1:0]  m_code = 2'd0;
  bit          e_fv   = 1'b0;
  bit          e_ev   = 1'b0;
  bit          e_busy = 1'b0;

  logic        obs_fv;
  logic        obs_ev;
  logic [1:0]  obs_code;
  logic        obs_busy;
  logic [0:FS] obs_fout;

  logic [7:0]  fr[$];

  task automatic chk(input string name, input logic [FS:0] act, input logic [FS:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32_of(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h000000, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void reject(input logic [1:0] code);
    e_ev   = 1'b1;
    m_code = code;
    m_in   = 1'b0;
    m_esc  = 1'b0;
  endfunction

  function automatic void model_step(input bit r, input bit v, input logic [7:0] b);
    e_fv = 1'b0;
    e_ev = 1'b0;
    if (r) begin
      m_in = 1'b0; m_esc = 1'b0; m_fout = '0; m_code = 2'd0;
    end else if (v) begin
      if (!m_in) begin
        if (b == START) begin m_in = 1'b1; m_esc = 1'b0; m_q.delete(); end
      end else if (m_esc) begin
        m_esc = 1'b0;
        if (b == START || b == FEND || b == ESC) reject(2'd2);
        else if (m_q.size() == FB) reject(2'd1);
        else m_q.push_back(b ^ XORV);
      end else if (b == ESC) begin
        m_esc = 1'b1;
      end else if (b == FEND) begin
        if (m_q.size() != FB) reject(2'd1);
`ifdef DEFRAMER_CRC_CHECK_EN
        else if (crc32_of(m_q, CRC_BYTES) != {m_q[74], m_q[73], m_q[72], m_q[71]}) reject(2'd3);
`endif
        else begin
          for (int k = 0; k < FB; k++) m_fout[8*k +: 8] = m_q[k];
          e_fv = 1'b1;
          m_in = 1'b0;
        end
      end else if (b == START) begin
        e_ev = 1'b1; m_code = 2'd1; m_q.delete();
      end else if (m_q.size() == FB) begin
        reject(2'd1);
      end else begin
        m_q.push_back(b);
      end
    end
    e_busy = m_in;
  endfunction

  // One clock: check what the previous strobe produced, then drive the next
  task automatic step(input bit r, input bit v, input logic [7:0] b);
    @(negedge clk);
    obs_fv = bus.fout_valid; obs_ev = bus.err_valid; obs_code = bus.err_code;
    obs_busy = bus.busy; obs_fout = bus.fout;
    chk("fout_valid", (FS+1)'(obs_fv), (FS+1)'(e_fv));
    chk("err_valid", (FS+1)'(obs_ev), (FS+1)'(e_ev));
    chk("err_code", (FS+1)'(obs_code), (FS+1)'(m_code));
    chk("busy", (FS+1)'(obs_busy), (FS+1)'(e_busy));
    chk("fout", obs_fout, m_fout);
    rst = r;
    bus.rx_valid = v;
    bus.rx_byte  = b;
    model_step(r, v, b);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] sp[3];
    sp[0] = START; sp[1] = FEND; sp[2] = ESC;
    if ($urandom_range(0, 5) == 0) return sp[$urandom_range(0, 2)];
    return 8'($urandom);
  endfunction

  task automatic make_payload(input int n, input int pat);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       fr.push_back(8'(i));
        1:       fr.push_back(rand_byte());
        default: fr.push_back(8'h00);
      endcase
    end
    if (CRC_ON && n == FB) begin
      c = crc32_of(fr, CRC_BYTES);
      for (int k = 0; k < 4; k++) fr[CRC_BYTES + k] = c[8*k +: 8];
    end
  endtask

  task automatic send_body(input bit gaps);
    foreach (fr[i]) begin
      if (gaps && $urandom_range(0, 7) == 0) step(1'b0, 1'b0, 8'h00);
      if (fr[i] == START || fr[i] == FEND || fr[i] == ESC) begin
        step(1'b0, 1'b1, ESC);
        step(1'b0, 1'b1, fr[i] ^ XORV);
      end else begin
        step(1'b0, 1'b1, fr[i]);
      end
    end
  endtask

  typedef struct {
    int         n;
    int         pat;
    int         kind;
    bit         exp_fv;
    bit         exp_ev;
    logic [1:0] exp_code;
  } vec_t;

  vec_t        tbl[10];
  logic [0:FS] saved_fout;
  logic [7:0]  esc_bad[3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{75, 0, K_PLAIN,   1'b1, 1'b0, 2'd0};
    tbl[1] = '{74, 1, K_PLAIN,   1'b0, 1'b1, 2'd1};
    tbl[2] = '{75, 1, K_PLAIN,   1'b1, 1'b0, 2'd1};
    tbl[3] = '{0,  1, K_PLAIN,   1'b0, 1'b1, 2'd1};
    tbl[4] = '{10, 1, K_BADESC,  1'b0, 1'b1, 2'd2};
    tbl[5] = '{75, 2, K_PLAIN,   1'b1, 1'b0, 2'd2};
    tbl[6] = '{76, 1, K_PLAIN,   1'b0, 1'b0, 2'd1};
    tbl[7] = '{75, 1, K_RESYNC,  1'b1, 1'b0, 2'd1};
    tbl[8] = '{75, 2, K_CRCFLIP, !CRC_ON, CRC_ON, CRC_ON ? 2'd3 : 2'd1};
    tbl[9] = '{75, 1, K_PLAIN,   1'b1, 1'b0, CRC_ON ? 2'd3 : 2'd1};
    esc_bad[0] = START; esc_bad[1] = FEND; esc_bad[2] = ESC;

    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 8'h00);

    for (int t = 0; t < 10; t++) begin
      if (tbl[t].kind == K_RESYNC) begin
        make_payload(30, 1);
        step(1'b0, 1'b1, START);
        send_body(1'b0);
      end
      make_payload(tbl[t].n, tbl[t].pat);
      if (tbl[t].kind == K_CRCFLIP) fr[FB-1] = fr[FB-1] ^ 8'h01;
      step(1'b0, 1'b1, START);
      send_body(1'b0);
      if (tbl[t].kind == K_BADESC) begin
        step(1'b0, 1'b1, ESC);
        step(1'b0, 1'b1, FEND);
      end else begin
        step(1'b0, 1'b1, FEND);
      end
      step(1'b0, 1'b0, 8'h00);
      chk($sformatf("vec%0d_fv", t), (FS+1)'(obs_fv), (FS+1)'(tbl[t].exp_fv));
      chk($sformatf("vec%0d_ev", t), (FS+1)'(obs_ev), (FS+1)'(tbl[t].exp_ev));
      chk($sformatf("vec%0d_code", t), (FS+1)'(obs_code), (FS+1)'(tbl[t].exp_code));
      if (t == 0) begin
        saved_fout = obs_fout;
        chk("inc_byte0", (FS+1)'(obs_fout[0:7]), (FS+1)'(8'h00));
        chk("stuffed_06", (FS+1)'(obs_fout[48:55]), (FS+1)'(8'h06));
        chk("stuffed_07", (FS+1)'(obs_fout[56:63]), (FS+1)'(8'h07));
        chk("stuffed_14", (FS+1)'(obs_fout[160:167]), (FS+1)'(8'h14));
`ifndef DEFRAMER_CRC_CHECK_EN
        chk("inc_byte74", (FS+1)'(obs_fout[592:599]), (FS+1)'(8'h4A));
`endif
      end
      if (t == 1) chk("short_keeps_fout", obs_fout, saved_fout);
      step(1'b0, 1'b0, 8'h00);
    end

    // Reset mid-frame: no pulses, outputs cleared, next frame accepted
    make_payload(30, 1);
    step(1'b0, 1'b1, START);
    send_body(1'b0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("rst_busy", (FS+1)'(obs_busy), '0);
    chk("rst_fout", obs_fout, '0);
    chk("rst_code", (FS+1)'(obs_code), '0);
    make_payload(FB, 1);
    step(1'b0, 1'b1, START);
    send_body(1'b0);
    step(1'b0, 1'b1, FEND);
    step(1'b0, 1'b0, 8'h00);
    chk("after_rst_fv", (FS+1)'(obs_fv), (FS+1)'(1'b1));

    // Back-to-back: START on the strobe right after END
    make_payload(FB, 1);
    step(1'b0, 1'b1, START);
    send_body(1'b0);
    step(1'b0, 1'b1, FEND);
    step(1'b0, 1'b1, START);
    chk("b2b_first_fv", (FS+1)'(obs_fv), (FS+1)'(1'b1));
    make_payload(FB, 0);
    send_body(1'b0);
    step(1'b0, 1'b1, FEND);
    step(1'b0, 1'b0, 8'h00);
    chk("b2b_second_fv", (FS+1)'(obs_fv), (FS+1)'(1'b1));

    // Random traffic judged solely by the frame model
    for (int f = 0; f < 40; f++) begin
      int sel;
      int noise;
      sel   = $urandom_range(0, 11);
      noise = $urandom_range(0, 3);
      for (int i = 0; i < noise; i++) begin
        logic [7:0] nb;
        nb = rand_byte();
        step(1'b0, 1'b1, (nb == START) ? 8'h55 : nb);
      end
      case (sel)
        6:       make_payload(FB - 1, 1);
        7:       make_payload(FB + 1, 1);
        8:       make_payload($urandom_range(0, FB + 5), 1);
        default: make_payload(FB, $urandom_range(1, 2));
      endcase
      if (sel == 9) fr[$urandom_range(0, FB - 1)] ^= 8'(1 << $urandom_range(0, 7));
      step(1'b0, 1'b1, START);
      if (sel == 10) begin
        fr = fr[0:$urandom_range(0, 20)];
        send_body(1'b1);
        step(1'b0, 1'b1, ESC);
        step(1'b0, 1'b1, esc_bad[$urandom_range(0, 2)]);
      end else begin
        send_body(1'b1);
        step(1'b0, 1'b1, FEND);
      end
      if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_deframer.md
Name: frame_deframer

Overview:
Receive-side deframer feeding the frame bus consumed by the interface/core path (fout / fout_valid).
- Takes the raw byte stream from the UART receiver.
- Hunts for FRAME_START, removes byte stuffing (ESC_VAL, then byte XOR ESC_XOR), and packs exactly PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE bytes into one wide frame word.
- Flags length, escape and (optionally) CRC errors so the sender can be answered with ERROR.

Parameters:
DATA_SIZE, 64, payload bytes per frame
PREAMBLE_SIZE, 7, preamble bytes (frame type byte included)
CRC_SIZE, 4, trailing CRC bytes
FRAME_START, 8'h06, start flag
FRAME_END, 8'h07, end flag
ESC_VAL, 8'h14, escape marker
ESC_XOR, 8'h20, value XORed into the byte following ESC_VAL
Derived (localparam): FRAME_BYTES = PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE (75); FRAME_SIZE = FRAME_BYTES*8-1 (599)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_byte  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_byte valid; no backpressure
fout  out  [0:FRAME_SIZE]  assembled frame; byte k at fout[8k:8k+7], byte 0 = first byte after FRAME_START
fout_valid  out  1  one-cycle pulse, fout holds a good frame
err_valid  out  1  one-cycle pulse on frame rejection
err_code  out  2  1=length, 2=escape, 3=crc; held until next err_valid
busy  out  1  high while a frame is being received (RECV/ESC)

Behaviour:
Reset: state=IDLE, byte count=0, fout=0, fout_valid=0, err_valid=0, err_code=0, busy=0.
- Reset is honoured at any time. A partial frame is discarded with no error pulse.

States:
- IDLE
  - rx_valid && rx_byte==FRAME_START -> RECV, count=0.
  - All other bytes ignored silently.
- RECV, on rx_valid:
  - ESC_VAL -> ESC.
  - FRAME_END -> if count==FRAME_BYTES (and CRC ok when enabled) pulse fout_valid, else pulse err_valid. In both cases -> IDLE.
  - FRAME_START -> resync: pulse err_valid code 1, count=0, stay RECV.
  - Any other byte -> store at index count, count+1.
  - If count is already FRAME_BYTES when a data byte arrives -> err code 1, -> IDLE.
- ESC, on rx_valid:
  - FRAME_START, FRAME_END or ESC_VAL -> err code 2, -> IDLE.
  - Otherwise store rx_byte^ESC_XOR, count+1 (same overflow rule as RECV), -> RECV.

Output timing and widths:
- fout_valid and err_valid are asserted the cycle after the FRAME_END strobe is sampled. They are mutually exclusive.
- Bytes are written into a shadow register. fout is copied from the shadow only on a good frame, so fout is stable between fout_valid pulses and a rejected frame never disturbs it.
- count is 7 bits wide, saturating-safe; overflow is detected before any write past FRAME_BYTES-1.
- Empty frame (START immediately followed by END) -> err code 1.
- Back-to-back frames: END followed by START on the very next strobe must be accepted.

Optional Feature:
Macro DEFRAMER_CRC_CHECK_EN.
- Defined:
  - CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over the unstuffed bytes 0..PREAMBLE_SIZE+DATA_SIZE-1.
  - One byte is processed per accepted byte with no added latency.
  - The result is compared against the last CRC_SIZE bytes, least significant byte first.
  - A mismatch at FRAME_END gives err code 3 and no fout update.
- Undefined: no CRC logic is built. CRC bytes pass into fout unchecked, and code 3 is never produced.

Decomposition:
- Shared package: frame flag constants (FRAME_START, FRAME_END, ESC_VAL, ESC_XOR), frame-type and confirmation codes, error-code enumeration (ERR_LEN=1, ERR_ESC=2, ERR_CRC=3), CRC-32 polynomial and init constants.
- Sub-module crc32_byte: combinational, 32-bit crc_in plus 8-bit data gives 32-bit crc_out. Instantiated only under DEFRAMER_CRC_CHECK_EN and reusable by the transmit framer.

Test Plan:
- Good frame: 06, bytes 0x00..0x4A (75 bytes, CRC disabled), 07 -> one fout_valid pulse, fout[0:7]=00, fout[592:599]=4A, err_valid=0.
- Stuffing: payload containing 14 26, 14 27, 14 34 -> stored bytes 06, 07, 14 at the correct indices; frame accepted.
- Length: 74 data bytes then 07 -> err_valid with code 1, fout unchanged. 76 data bytes -> err code 1 on the 76th byte, then the following 07 is ignored while in IDLE.
- Bad escape: 06, 10 bytes, 14 07 -> err code 2. A subsequent good frame is accepted normally.
- Resync and reset: 06, 30 bytes, 06, then a full good frame -> err code 1 followed by fout_valid. rst asserted mid-frame -> no pulses; the next good frame is accepted.
- With DEFRAMER_CRC_CHECK_EN: correct CRC-32 of 71 bytes of 0x00 appended -> fout_valid. The same frame with one CRC bit flipped -> err code 3, fout unchanged.
